// File: rtl/uart_rx_if.sv
// Bus-side port bundle for uart_rx: FIFO read port, sticky error flags and status.
interface uart_rx_if #(
  parameter int FIFO_AW = 4
);
  logic               rd_en;
  logic               err_clr;
  logic [7:0]         data;
  logic               empty;
  logic               full;
  logic [FIFO_AW:0]   count;
  logic               busy;
  logic               overrun;
  logic               frame_err;

  modport master (
    output rd_en, err_clr,
    input  data, empty, full, count, busy, overrun, frame_err
  );

  modport slave (
    input  rd_en, err_clr,
    output data, empty, full, count, busy, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, bytes buffered in a
// first-word-fall-through FIFO with sticky overrun / framing-error flags.
module uart_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       clk_uart16,
  input  logic       RXD,
  uart_rx_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW+1)'(1);

  logic         sync1_q, sync2_q, rxd_s;
  state_t       state_q, state_d;
  logic [3:0]   tick_q, tick_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shift_q, shift_d;
  logic         arm_q, arm_d;
  logic         busy_q, busy_d;
  logic         frame_err_q, frame_err_d;
  logic         overrun_q, overrun_d;
  logic         push, ferr_ev, pop, wr_ok, ovr_ev, full_w;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  assign rxd_s = sync2_q;

  // arm_q requires the line to be seen high after a frame before the next
  // falling edge may start one; a low stop bit must not re-trigger.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    arm_d   = arm_q | rxd_s;
    push    = 1'b0;
    ferr_ev = 1'b0;
    if (state_q != IDLE && clk_uart16) tick_d = tick_q + 4'd1;
    case (state_q)
      IDLE:  if (!rxd_s && arm_q) state_d = START;
      START: if (clk_uart16 && tick_q == 4'd7) begin
        state_d = rxd_s ? IDLE : DATA;
        bit_d   = 3'd0;
      end
      DATA:  if (clk_uart16 && tick_q == 4'd15) begin
        shift_d[bit_q] = rxd_s;
        bit_d          = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP:  if (clk_uart16 && tick_q == 4'd15) begin
        state_d = IDLE;
        push    = rxd_s;
        ferr_ev = ~rxd_s;
        arm_d   = rxd_s;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tick_d = 4'd0;
    busy_d = (state_d != IDLE);
  end

  // When full, a same-cycle pop frees the slot the push lands in.
  always_comb begin
    full_w   = (count_q == CNT_FULL);
    pop      = bus.rd_en && (count_q != '0);
    wr_ok    = push && (!full_w || bus.rd_en);
    ovr_ev   = push && full_w && !bus.rd_en;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !pop) count_d = count_q + CNT_ONE;
    else if (!wr_ok && pop) count_d = count_q - CNT_ONE;
    frame_err_d = (frame_err_q & ~bus.err_clr) | ferr_ev;
    overrun_d   = (overrun_q & ~bus.err_clr) | ovr_ev;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      tick_q      <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      arm_q       <= 1'b1;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
    end else begin
      sync1_q     <= RXD;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      arm_q       <= arm_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.data      = mem_q[rd_ptr_q];
  assign bus.empty     = (count_q == '0);
  assign bus.full      = full_w;
  assign bus.count     = count_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, FIFO drained and
// compared against hand-computed bytes and flag states.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  // Ticks from START entry to the stop-bit sample: 8 + 8*16 + 16.
  localparam int STOP_TICK = 152;

  logic clk = 1'b0, rst = 1'b1, clk_uart16 = 1'b0, rxd = 1'b1;
  logic rd_man = 1'b0, rd_auto = 1'b0, clr_man = 1'b0, clr_auto = 1'b0;
  int   div = 27, auto_sel = 0, tick_cnt = 0, since = 0;
  int   checks = 0, fails = 0;

  uart_rx_if #(.FIFO_AW(AW)) bus();
  assign bus.rd_en   = rd_man | rd_auto;
  assign bus.err_clr = clr_man | clr_auto;

  uart_rx #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .RST(rst), .clk_uart16(clk_uart16), .RXD(rxd), .bus(bus)
  );

  always #10 clk = ~clk;

  // Tick generator; also pulses rd_en / err_clr exactly on the stop-sample cycle.
  initial begin
    forever begin
      @(negedge clk);
      tick_cnt++;
      clk_uart16 = (tick_cnt >= div);
      if (clk_uart16) tick_cnt = 0;
      if (!bus.busy) since = 0;
      else if (clk_uart16) since++;
      rd_auto  = (auto_sel == 1) && clk_uart16 && (since == STOP_TICK);
      clr_auto = (auto_sel == 2) && clk_uart16 && (since == STOP_TICK);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bitw();
    clks(16 * div);
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    rxd = 1'b0; bitw();
    for (int i = 0; i < 8; i++) begin rxd = b[i]; bitw(); end
    rxd = stopb; bitw();
    rxd = 1'b1; bitw();
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    chk(tag, bus.data, exp);
    rd_man = 1'b1; clks(1); rd_man = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       prev_e, got;
    clks(3);
    chk("rst_data", bus.data, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_ferr", bus.frame_err, 0);
    rst = 1'b0; clks(5);

    // 0xA5 at tick every 27 clk; byte must appear exactly with the stop-sample edge
    b = 8'hA5;
    rxd = 1'b0; bitw();
    for (int i = 0; i < 8; i++) begin rxd = b[i]; bitw(); end
    rxd = 1'b1;
    prev_e = 1'b1; got = 1'b0;
    for (int n = 0; n < 16 * 27 + 100; n++) begin
      @(negedge clk);
      if (!bus.busy) begin got = 1'b1; break; end
      prev_e = bus.empty;
    end
    chk("t1_done", got, 1);
    chk("t1_empty_before", prev_e, 1);
    chk("t1_empty_after", bus.empty, 0);
    chk("t1_data", bus.data, 8'hA5);
    chk("t1_count", bus.count, 1);
    chk("t1_ferr", bus.frame_err, 0);
    chk("t1_ovr", bus.overrun, 0);
    bitw();
    rd_chk("t1_pop", 8'hA5);
    chk("t1_empty", bus.empty, 1);

    div = 3; clks(50);

    // 3-tick glitch
    rxd = 1'b0; clks(3 * div); rxd = 1'b1; clks(4);
    chk("t2_busy", bus.busy, 1);
    bitw();
    chk("t2_idle", bus.busy, 0);
    chk("t2_empty", bus.empty, 1);
    chk("t2_ferr", bus.frame_err, 0);
    chk("t2_ovr", bus.overrun, 0);

    // bad stop bit, err_clr on the very error cycle (set wins)
    auto_sel = 2; send(8'h3C, 1'b0); auto_sel = 0;
    chk("t3_ferr", bus.frame_err, 1);
    chk("t3_empty", bus.empty, 1);
    chk("t3_busy", bus.busy, 0);
    clr_man = 1'b1; clks(1); clr_man = 1'b0;
    chk("t3_clr", bus.frame_err, 0);

    // 17 bytes, no reads
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1);
    chk("t4_full", bus.full, 1);
    chk("t4_count", bus.count, 16);
    chk("t4_ovr", bus.overrun, 1);
    chk("t4_ferr", bus.frame_err, 0);
    for (int i = 0; i < 16; i++) rd_chk("t4_rd", 8'(i));
    chk("t4_empty", bus.empty, 1);
    chk("t4_count0", bus.count, 0);
    rd_man = 1'b1; clks(1); rd_man = 1'b0;
    chk("t4_no_underflow", bus.count, 0);
    clr_man = 1'b1; clks(1); clr_man = 1'b0;
    chk("t4_clr", bus.overrun, 0);

    // full FIFO, pop coincides with the push of 0x55
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1);
    chk("t5_full", bus.full, 1);
    auto_sel = 1; send(8'h55, 1'b1); auto_sel = 0;
    chk("t5_count", bus.count, 16);
    chk("t5_ovr", bus.overrun, 0);
    for (int i = 1; i < 16; i++) rd_chk("t5_rd", 8'h20 + 8'(i));
    rd_chk("t5_last", 8'h55);
    chk("t5_empty", bus.empty, 1);

    // reset mid-frame of 0xFF with a byte already queued
    send(8'h77, 1'b1);
    chk("t6_pre", bus.count, 1);
    rxd = 1'b0; bitw();
    for (int i = 0; i < 4; i++) begin rxd = 1'b1; bitw(); end
    clks(4 * div);
    rst = 1'b1; clks(2);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_empty", bus.empty, 1);
    rst = 1'b0; clks(32 * div);
    chk("t6_idle", bus.busy, 0);
    chk("t6_count0", bus.count, 0);
    send(8'h12, 1'b1);
    chk("t6_count", bus.count, 1);
    chk("t6_data", bus.data, 8'h12);
    chk("t6_ferr", bus.frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive stage. It is the peer of the team's UART transmitter and consumes the serial line that transmitter drives: 8N1 framing, LSB first, idle high.
- It oversamples RXD on a 16x baud tick, deserialises each frame, and buffers received bytes in an internal FIFO.
- The bus-side peripheral logic drains the FIFO through a first-word-fall-through read port.
- It sits between the board RXD pin and the UART register interface.

Parameters:
- FIFO_DEPTH, 16, number of byte entries in the receive FIFO; power of two, minimum 2.
- FIFO_AW, 4, FIFO pointer width; equals log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all logic is in this single domain.
- RST  input  1  asynchronous, active-high reset.
- clk_uart16  input  1  one-clk-wide tick at 16x the baud rate, generated externally.
- RXD  input  1  asynchronous serial line.
- rd_en  input  1  pops the FIFO head; ignored when empty.
- err_clr  input  1  clears the sticky error flags.
- data  output  8  FIFO head byte; valid when empty=0.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- count  output  FIFO_AW+1  number of bytes held.
- busy  output  1  high while the receive FSM is not in IDLE.
- overrun  output  1  sticky; a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky; a stop bit was sampled as 0.

Behaviour:
- Reset (asynchronous, RST=1):
  - Outputs: data=0, empty=1, full=0, count=0, busy=0, overrun=0, frame_err=0.
  - Internals: synchroniser flops=1, FSM in IDLE, FIFO pointers=0.
- Input synchroniser: RXD passes through 2 flops to give rxd_s, so there are 2 clk of latency before the FSM sees a line change.
- Timing base: the 4-bit tick counter advances only on cycles with clk_uart16=1. Every FSM state change clears it.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rxd_s=0, go to START. busy rises on the next clk.
  - START: on the 8th tick (mid-bit), sample rxd_s.
    - If 0, go to DATA with bit index=0.
    - If 1, treat it as a glitch and return to IDLE; no flags change.
  - DATA: on every 16th tick, sample rxd_s into shift[bit index], LSB first. After bit 7 is sampled, go to STOP.
  - STOP: on the 16th tick, sample rxd_s.
    - If 1, push the byte to the FIFO.
    - If 0, set frame_err and discard the byte.
    - Either way, return to IDLE. The line must go high and then low again before a new frame can start.
- FIFO push rules:
  - If count<FIFO_DEPTH, write the byte.
  - If full and rd_en=1 in the same cycle, the push is accepted together with the pop and count is unchanged.
  - If full and rd_en=0, drop the byte and set overrun.
- FIFO read side (first-word-fall-through):
  - data is a combinational read of the head entry.
  - rd_en with empty=0 advances the read pointer at the next edge.
  - rd_en with empty=1 has no effect; count does not underflow.
- Pointers are FIFO_AW bits wide and wrap naturally modulo FIFO_DEPTH. count is the registered occupancy:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
  - empty = (count==0); full = (count==FIFO_DEPTH).
- Byte latency: the byte is visible on data/empty one clk after the STOP sampling tick.
- Sticky flags:
  - err_clr clears both flags.
  - If a new error event and err_clr occur in the same cycle, the flag ends up set (set wins).
- Reset asserted mid-frame: the partial byte is lost, the FIFO is emptied, and the FSM returns to IDLE. If RXD is low when reset releases, that starts a frame immediately.
- Ticks arriving while the FSM is in IDLE are ignored.

Test Plan:
- Single byte 0xA5 at 115200 baud (clk 50 MHz, tick every 27 clk) -> data=0xA5, empty=0 one clk after the stop sample, count=1, frame_err=0, overrun=0.
- 3-tick low pulse on idle RXD -> FSM returns to IDLE from START, empty stays 1, no flags set.
- Frame 0x3C sent with stop bit=0 -> frame_err=1, empty stays 1; err_clr pulse -> frame_err=0.
- 17 bytes 0x00..0x10 with no reads -> full=1, count=16, overrun=1, and reads return 0x00..0x0F in order.
- FIFO full with rd_en asserted on the push cycle of byte 0x55 -> count stays 16, overrun stays 0, and 0x55 is read last.
- RST pulse after the 4th data bit of 0xFF, followed by a complete 0x12 frame -> only 0x12 is received, count=1.
